// File: rtl/alu.sv
// alu: registered WIDTH-bit arithmetic/logic unit with per-opcode carry/borrow/shift-out flag
module alu #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] out,
   output logic             c
);
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic [WIDTH-1:0] nxt_out;
   logic             nxt_c;
   assign sum = {1'b0, a} + {1'b0, b};
   // the top bit of the widened difference is the unsigned borrow
   assign dif = {1'b0, a} - {1'b0, b};
   always_comb begin
      nxt_out = '0;
      nxt_c   = 1'b0;
      case (op)
         3'd0: {nxt_c, nxt_out} = sum;
         3'd1: {nxt_c, nxt_out} = dif;
         3'd2: nxt_out = a & b;
         3'd3: nxt_out = a | b;
         3'd4: nxt_out = a ^ b;
         3'd5: nxt_out = ~a;
         3'd6: {nxt_c, nxt_out} = {a, 1'b0};
         3'd7: {nxt_out, nxt_c} = {1'b0, a};
         default: begin
            nxt_out = 'x;
            nxt_c   = 1'bx;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
         c   <= 1'b0;
      end else begin
         out <= nxt_out;
         c   <= nxt_c;
      end
   end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu with hand-computed vectors and a back-to-back reference model
module tb_alu;
   localparam int W = 4;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = '0;
   logic [W-1:0] out;
   logic         c;
   int           checks = 0;
   int           errors = 0;

   alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .out(out), .c(c));

   always #5 clk = ~clk;

   localparam int ADD_A[3] = '{9, 3, 15};
   localparam int ADD_B[3] = '{8, 4, 1};
   localparam int ADD_O[3] = '{1, 7, 0};
   localparam int ADD_C[3] = '{1, 0, 1};
   localparam int SUB_A[3] = '{2, 7, 9};
   localparam int SUB_B[3] = '{5, 7, 3};
   localparam int SUB_O[3] = '{13, 0, 6};
   localparam int SUB_C[3] = '{1, 0, 0};
   localparam int LOG_O[4] = '{8, 14, 6, 3};
   localparam int SH_A[3]  = '{9, 9, 6};
   localparam int SH_OP[3] = '{6, 7, 7};
   localparam int SH_O[3]  = '{2, 4, 3};
   localparam int SH_C[3]  = '{1, 1, 0};

   // apply inputs on the falling edge, then land just after the next rising edge
   task automatic drive(input int ta, input int tb, input int top);
      @(negedge clk);
      a  = ta[W-1:0];
      b  = tb[W-1:0];
      op = top[2:0];
      @(posedge clk);
      #1;
   endtask

   function automatic int model(input int ma, input int mb, input int mop);
      int r;
      int f;
      r = 0;
      f = 0;
      case (mop)
         0: begin r = (ma + mb) % 16; f = (ma + mb > 15) ? 1 : 0; end
         1: begin r = (ma - mb + 16) % 16; f = (ma < mb) ? 1 : 0; end
         2: r = ma & mb;
         3: r = ma | mb;
         4: r = ma ^ mb;
         5: r = 15 - ma;
         6: begin r = (ma * 2) % 16; f = ma / 8; end
         default: begin r = ma / 2; f = ma % 2; end
      endcase
      return f * 16 + r;
   endfunction

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({c, out} !== 5'h00) begin
         errors++;
         $display("FAIL reset_init out=%0h c=%0b exp out=0 c=0", out, c);
      end
      @(negedge clk) rst_n = 1'b1;
      drive(5, 5, 0);
      checks++;
      if ({c, out} !== 5'h0A) begin
         errors++;
         $display("FAIL reset_pre out=%0h c=%0b exp out=a c=0", out, c);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({c, out} !== 5'h00) begin
         errors++;
         $display("FAIL reset_async out=%0h c=%0b exp out=0 c=0", out, c);
      end
      drive(15, 1, 0);
      checks++;
      if ({c, out} !== 5'h00) begin
         errors++;
         $display("FAIL reset_hold out=%0h c=%0b exp out=0 c=0", out, c);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({c, out} !== 5'h10) begin
         errors++;
         $display("FAIL reset_release out=%0h c=%0b exp out=0 c=1", out, c);
      end
   endtask

   task automatic test_add;
      for (int i = 0; i < 3; i++) begin
         drive(ADD_A[i], ADD_B[i], 0);
         checks++;
         if (out !== ADD_O[i][W-1:0] || c !== ADD_C[i][0]) begin
            errors++;
            $display("FAIL add%0d out=%0d c=%0b exp out=%0d c=%0d", i, out, c, ADD_O[i], ADD_C[i]);
         end
      end
   endtask

   task automatic test_sub;
      for (int i = 0; i < 3; i++) begin
         drive(SUB_A[i], SUB_B[i], 1);
         checks++;
         if (out !== SUB_O[i][W-1:0] || c !== SUB_C[i][0]) begin
            errors++;
            $display("FAIL sub%0d out=%0d c=%0b exp out=%0d c=%0d", i, out, c, SUB_O[i], SUB_C[i]);
         end
      end
   endtask

   task automatic test_logic;
      for (int i = 0; i < 4; i++) begin
         drive(9, 8, 0);
         drive(12, 10, i + 2);
         checks++;
         if (out !== LOG_O[i][W-1:0] || c !== 1'b0) begin
            errors++;
            $display("FAIL logic_op%0d out=%b c=%0b exp out=%b c=0", i + 2, out, c, LOG_O[i][W-1:0]);
         end
      end
   endtask

   task automatic test_shift;
      for (int i = 0; i < 3; i++) begin
         drive(SH_A[i], 0, SH_OP[i]);
         checks++;
         if (out !== SH_O[i][W-1:0] || c !== SH_C[i][0]) begin
            errors++;
            $display("FAIL shift%0d out=%b c=%0b exp out=%b c=%0d", i, out, c, SH_O[i][W-1:0], SH_C[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int exp_v;
      int prev;
      prev = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (prev >= 0) begin
            checks++;
            if ({c, out} !== prev[W:0]) begin
               errors++;
               $display("FAIL b2b_hold%0d got=%0h exp=%0h", i, {c, out}, prev[W:0]);
            end
         end
         a  = 4'd5;
         b  = 4'd3;
         op = i[2:0];
         exp_v = model(5, 3, i);
         @(posedge clk);
         #1;
         checks++;
         if ({c, out} !== exp_v[W:0]) begin
            errors++;
            $display("FAIL b2b_op%0d got=%0h exp=%0h", i, {c, out}, exp_v[W:0]);
         end
         prev = exp_v;
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_logic;
      test_shift;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
